coin_serial_tx: RTL and testbench
=================================

Name: coin_serial_tx

Overview:
- Transmit end of the vending machine's serial coin interface; emulates the coin acceptor.
- Queues coin-insert requests and serialises each one as a 12-bit coin frame on serialOut/enable, one bit per clock, LSB first.
- Output pair connects directly to the vending machine's serialIn/enable inputs.
- Used as a reusable stimulus source and as the acceptor-side model in system builds.

Parameters:
- FRAME_W, 12, bits per coin frame.
- FIFO_DEPTH, 4, request queue depth; power of two, minimum 2.
- PENNY_CODE, 12'b1011_1100_0000, frame for coin_type 0.
- NICKEL_CODE, 12'b1101_0000_0000, frame for coin_type 1.
- DIME_CODE, 12'b1011_0000_0000, frame for coin_type 2.
- QUARTER_CODE, 12'b1110_1111_0000, frame for coin_type 3.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- coin_valid  in  1  request present.
- coin_type  in  2  0=penny, 1=nickel, 2=dime, 3=quarter.
- coin_ready  out  1  queue can accept; equals !full.
- serialOut  out  1  frame data bit, registered.
- enable  out  1  frame strobe, registered; low marks a frame boundary.
- busy  out  1  high in SEND or FLUSH, or when the queue is non-empty.
- frames_sent  out  8  count of completed frames; wraps 255->0.

Behaviour:
- Reset (reset=0, async):
  - Queue emptied, state IDLE, bit index 0, frames_sent=0.
  - serialOut=0, enable=1, coin_ready=1, busy=0.
  - Reset asserted mid-frame aborts the frame immediately; the partial frame is not counted.
- Request handshake:
  - A request is pushed at the rising edge where coin_valid && coin_ready.
  - coin_type is mapped to its code at push time, and the 12-bit code is stored in the queue.
  - When full, coin_ready=0, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full: both take effect and the count is unchanged.
- States: IDLE, SEND, FLUSH.
- IDLE:
  - Outputs serialOut=0, enable=1.
  - If the queue is non-empty at an edge: pop into the shift register, go to SEND with bit index 0.
- SEND, bit 0 cycle:
  - serialOut=code[0], enable=0.
- SEND, bit k cycle (k=1..11):
  - serialOut=code[k], enable=1.
  - Bit index increments each edge.
- End of frame, at the edge leaving bit 11:
  - frames_sent increments.
  - If the queue is non-empty: pop and start the next frame's bit 0 directly. Frames are back-to-back with no gap; that bit-0 enable-low strobe also commits the previous frame.
  - Otherwise go to FLUSH.
- FLUSH:
  - One cycle with serialOut=0, enable=0. This is the commit strobe for the last frame.
  - Next edge: go to SEND (pop) if the queue is non-empty, else go to IDLE.
- Latency: a push at edge N gives the bit-0 cycle starting at edge N+1. The frame occupies edges N+1..N+12, and frames_sent updates at N+13.
- Frame period: exactly FRAME_W cycles back-to-back; FRAME_W+1 cycles when followed by FLUSH.
- coin_type is sampled only at push; later changes do not affect queued frames.
- Queue pointers wrap modulo FIFO_DEPTH; the count is held separately so full and empty are unambiguous.

Test Plan:
- Single penny:
  - Stimulus: reset release, one push of type 0.
  - Required: after 1 cycle, enable low for 1 cycle with serialOut bits 0..11 = 0,0,0,0,0,0,1,1,1,1,0,1, then one FLUSH cycle (enable=0, serialOut=0), then enable=1.
  - frames_sent=1.
- Back-to-back frames:
  - Stimulus: push types 0,1,2,3 on consecutive cycles.
  - Required: 48 contiguous bit cycles, enable low exactly at bit 0 of each frame, one FLUSH cycle after the quarter.
  - frames_sent=4, busy falls after FLUSH.
- Backpressure:
  - Stimulus: hold coin_valid=1 for 10 cycles during an active frame.
  - Required: coin_ready falls once 4 entries are queued.
  - Stalled requests are not lost or duplicated; exactly the accepted count is transmitted.
- Reset mid-frame:
  - Stimulus: assert reset during bit 5 of a dime with 2 frames queued.
  - Required: serialOut=0, enable=1 asynchronously; queue empty; frames_sent=0; no frame emitted after release until a new push.
- Counter wrap:
  - Stimulus: push 257 quarters.
  - Required: frames_sent reads 255 then 0 then 1; every frame equals QUARTER_CODE.
- Loopback:
  - Stimulus: connect to the vending machine; send 4 quarters, then 1 more frame.
  - Required: the credit display shows 100 cents after the FLUSH commit.

Source files
------------

// File: rtl/coin_serial_tx_if.sv
// Coin request channel between a request source and coin_serial_tx.
//   coin_valid : request present (source -> transmitter)
//   coin_type  : 0=penny, 1=nickel, 2=dime, 3=quarter (source -> transmitter)
//   coin_ready : transmitter queue can accept a request (transmitter -> source)
// A request transfers on the rising clock edge where coin_valid && coin_ready.
interface coin_serial_tx_if;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       coin_ready;

  modport master (output coin_valid, output coin_type, input coin_ready);
  modport slave  (input coin_valid, input coin_type, output coin_ready);
endinterface

// File: rtl/coin_serial_tx.sv
// Coin acceptor emulator: queues coin-insert requests and sends each one as a
// FRAME_W-bit coin frame, LSB first, one bit per clock on serialOut/enable.
// enable drops for the first bit of every frame, and for one FLUSH cycle after
// the last frame of a burst, so the receiver can commit the frame just sent.
// Ports:
//   clk         : single clock, rising edge
//   reset       : asynchronous, active-low
//   req         : coin request channel (slave side: coin_valid/coin_type in, coin_ready out)
//   serialOut   : frame data bit, registered
//   enable      : frame strobe, registered; low marks a frame boundary
//   busy        : high while sending/flushing or while requests are queued
//   frames_sent : completed frame count, wraps 255 -> 0
module coin_serial_tx #(
  parameter int                 FRAME_W      = 12,
  parameter int                 FIFO_DEPTH   = 4,
  parameter logic [FRAME_W-1:0] PENNY_CODE   = 12'b1011_1100_0000,
  parameter logic [FRAME_W-1:0] NICKEL_CODE  = 12'b1101_0000_0000,
  parameter logic [FRAME_W-1:0] DIME_CODE    = 12'b1011_0000_0000,
  parameter logic [FRAME_W-1:0] QUARTER_CODE = 12'b1110_1111_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  coin_serial_tx_if.slave        req,
  output logic                   serialOut,
  output logic                   enable,
  output logic                   busy,
  output logic [7:0]             frames_sent
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W = $clog2(FRAME_W);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_t;

  state_t             state;
  logic [FRAME_W-1:0] fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W-1:0]   rdPtr;
  logic [CNT_W-1:0]   count;
  logic [FRAME_W-1:0] shiftReg;
  logic [IDX_W-1:0]   bitIdx;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [FRAME_W-1:0] pushCode;
  logic [FRAME_W-1:0] popCode;

  // The occupancy count is kept apart from the pointers so full and empty are
  // never ambiguous. A new frame may load whenever the line is not mid-frame,
  // or on the last bit of the current frame, which gives back-to-back frames.
  always_comb begin
    full     = (count == FULL_CNT);
    empty    = (count == '0);
    push     = req.coin_valid && !full;
    pop      = !empty && ((state != SEND) || (bitIdx == LAST_BIT));
    busy     = (state != IDLE) || !empty;
    popCode  = fifoMem[rdPtr];
    pushCode = PENNY_CODE;
    case (req.coin_type)
      2'd0:    pushCode = PENNY_CODE;
      2'd1:    pushCode = NICKEL_CODE;
      2'd2:    pushCode = DIME_CODE;
      default: pushCode = QUARTER_CODE;
    endcase
  end

  // Ready depends only on fullness, so a pop in the same cycle never re-opens it.
  assign req.coin_ready = !full;

  // Queue storage holds the already-mapped code, so later coin_type changes
  // cannot alter a queued frame.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr] <= pushCode;
    end
  end

  // Queue pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Line FSM. Outputs are registered: the value loaded at an edge is the value
  // driven for the cycle that edge starts. Any pop starts a frame's bit 0 with
  // enable low; otherwise the state decides what the line shows.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bitIdx      <= '0;
      shiftReg    <= '0;
      serialOut   <= 1'b0;
      enable      <= 1'b1;
      frames_sent <= '0;
    end else begin
      if ((state == SEND) && (bitIdx == LAST_BIT)) begin
        frames_sent <= frames_sent + 8'd1;
      end
      if (pop) begin
        state     <= SEND;
        bitIdx    <= '0;
        serialOut <= popCode[0];
        shiftReg  <= popCode >> 1;
        enable    <= 1'b0;
      end else begin
        case (state)
          SEND: begin
            if (bitIdx == LAST_BIT) begin
              state     <= FLUSH;
              serialOut <= 1'b0;
              enable    <= 1'b0;
            end else begin
              bitIdx    <= bitIdx + 1'b1;
              serialOut <= shiftReg[0];
              shiftReg  <= shiftReg >> 1;
              enable    <= 1'b1;
            end
          end
          default: begin
            state     <= IDLE;
            serialOut <= 1'b0;
            enable    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_coin_serial_tx.sv
// Self-checking bench for coin_serial_tx. A line-position reference model
// predicts every output each cycle; a simple frame receiver decodes the serial
// line into coins and credit; directed steps cover the listed scenarios.
module tb_coin_serial_tx;

  localparam int          DEPTH     = 4;
  localparam int          FLUSH_POS = 12;
  localparam logic [11:0] PENNY     = 12'b1011_1100_0000;
  localparam logic [11:0] NICKEL    = 12'b1101_0000_0000;
  localparam logic [11:0] DIME      = 12'b1011_0000_0000;
  localparam logic [11:0] QUARTER   = 12'b1110_1111_0000;

  logic       clk        = 1'b0;
  logic       reset      = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type  = 2'd0;
  logic       serialOut;
  logic       enable;
  logic       busy;
  logic [7:0] frames_sent;

  int assertCount = 0;
  int failCount   = 0;
  bit chkEn       = 1'b0;

  coin_serial_tx_if req();
  assign req.coin_valid = coin_valid;
  assign req.coin_type  = coin_type;

  coin_serial_tx dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .serialOut   (serialOut),
    .enable      (enable),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] codeFor(input logic [1:0] kind);
    case (kind)
      2'd0:    return PENNY;
      2'd1:    return NICKEL;
      2'd2:    return DIME;
      default: return QUARTER;
    endcase
  endfunction

  // Reference model: a queue of pending codes plus the line position
  // (-1 idle, 0..11 frame bit, 12 flush). A frame ends after bit 11 and the
  // next queued code follows immediately, else one flush cycle is inserted.
  logic [11:0] mQueue[$];
  logic [11:0] mCur      = '0;
  int          mPos      = -1;
  logic [7:0]  mFrames   = '0;
  int          mAccepted = 0;
  bit          mAccept;
  bit          mDone;
  bit          mLoad;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mQueue.delete();
      mPos    = -1;
      mCur    = '0;
      mFrames = '0;
    end else begin
      mAccept = coin_valid && (mQueue.size() < DEPTH);
      mDone   = (mPos == 11);
      mLoad   = (mPos == -1) || (mPos == FLUSH_POS) || mDone;
      if (mDone) mFrames = mFrames + 8'd1;
      if (mLoad && mQueue.size() > 0) begin
        mCur = mQueue.pop_front();
        mPos = 0;
      end else if (mDone) begin
        mPos = FLUSH_POS;
      end else if (mPos == FLUSH_POS) begin
        mPos = -1;
      end else if (mPos >= 0) begin
        mPos = mPos + 1;
      end
      if (mAccept) begin
        mQueue.push_back(codeFor(coin_type));
        mAccepted++;
      end
    end
  end

  // Receiver: an enable-low cycle is a frame boundary; a complete 12-bit frame
  // collected before it is committed if it matches a coin code.
  logic [11:0] rxBits     = '0;
  int          rxCount    = 0;
  int          rxFrames   = 0;
  int          rxCredit   = 0;
  int          rxQuarters = 0;

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      rxBits  = '0;
      rxCount = 0;
    end else if (!enable) begin
      if (rxCount == 12) begin
        case (rxBits)
          PENNY:   begin rxFrames++; rxCredit += 1;  end
          NICKEL:  begin rxFrames++; rxCredit += 5;  end
          DIME:    begin rxFrames++; rxCredit += 10; end
          QUARTER: begin rxFrames++; rxCredit += 25; rxQuarters++; end
          default: ;
        endcase
      end
      rxBits  = {11'b0, serialOut};
      rxCount = 1;
    end else if (rxCount > 0 && rxCount < 12) begin
      rxBits[rxCount] = serialOut;
      rxCount++;
    end
  end

  // Line log of {enable, serialOut} and a log of frames_sent changes.
  logic [1:0] lineLog[$];
  bit         logEn   = 1'b0;
  logic [11:0] expFrames[$];
  logic [7:0] fsLog[$];
  bit         fsLogEn = 1'b0;
  logic [7:0] fsPrev  = '0;

  always @(negedge clk) begin
    if (logEn) lineLog.push_back({enable, serialOut});
    if (fsLogEn && frames_sent !== fsPrev) fsLog.push_back(frames_sent);
    fsPrev = frames_sent;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkModel();
    logic expSer;
    logic expEn;
    expEn  = !(mPos == 0 || mPos == FLUSH_POS);
    expSer = (mPos >= 0 && mPos < 12) ? mCur[mPos] : 1'b0;
    checkOutput("serialOut", serialOut, expSer);
    checkOutput("enable", enable, expEn);
    checkOutput("busy", busy, (mPos != -1) || (mQueue.size() != 0));
    checkOutput("coin_ready", req.coin_ready, mQueue.size() < DEPTH);
    checkOutput("frames_sent", frames_sent, mFrames);
  endtask

  // Cycle-by-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (chkEn) checkModel();
  end

  task automatic applyStimulus(input logic valid, input logic [1:0] kind);
    @(negedge clk);
    coin_valid = valid;
    coin_type  = kind;
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(input int maxCycles);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy === 1'b0 && mPos == -1 && mQueue.size() == 0) && n < maxCycles);
    checkOutput("drain_busy", busy, 0);
  endtask

  // Checks the logged line against expFrames: contiguous frames from the first
  // strobe, bit 0 strobed, then one flush cycle and a return to idle.
  task automatic checkLine(input string tag);
    int start;
    int n;
    int need;
    logic [1:0] want;
    start = -1;
    n = expFrames.size();
    for (int i = 0; i < lineLog.size(); i++) begin
      if (lineLog[i][1] == 1'b0) begin
        start = i;
        break;
      end
    end
    need = start + 12 * n + 2;
    checkOutput({tag, "_strobe"}, start >= 0, 1);
    checkOutput({tag, "_length"}, lineLog.size() >= need, 1);
    if (start >= 0 && lineLog.size() >= need) begin
      for (int f = 0; f < n; f++) begin
        for (int k = 0; k < 12; k++) begin
          want = {k != 0, expFrames[f][k]};
          checkOutput($sformatf("%s_f%0d_b%0d", tag, f, k), lineLog[start + 12 * f + k], want);
        end
      end
      checkOutput({tag, "_flush"}, lineLog[start + 12 * n], 2'b00);
      checkOutput({tag, "_idle"}, lineLog[start + 12 * n + 1], 2'b10);
    end
  endtask

  initial begin
    int base;
    int baseRx;
    int baseCredit;
    int guard;
    int lowCount;
    bit sawFull;

    $display("[TB] coin_serial_tx bench starting");
    chkEn = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_serialOut", serialOut, 0);
    checkOutput("rst_enable", enable, 1);
    checkOutput("rst_ready", req.coin_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_frames", frames_sent, 0);
    reset = 1'b1;

    // Single penny
    lineLog.delete();
    logEn = 1'b1;
    applyStimulus(1'b1, 2'd0);
    applyStimulus(1'b0, 2'd0);
    waitIdle(40);
    repeat (2) @(negedge clk);
    logEn = 1'b0;
    expFrames = '{PENNY};
    checkLine("penny");
    checkOutput("penny_frames", frames_sent, 1);
    checkOutput("penny_rx", rxFrames, 1);

    // Back-to-back frames
    lineLog.delete();
    logEn = 1'b1;
    applyStimulus(1'b1, 2'd0);
    applyStimulus(1'b1, 2'd1);
    applyStimulus(1'b1, 2'd2);
    applyStimulus(1'b1, 2'd3);
    applyStimulus(1'b0, 2'd0);
    waitIdle(100);
    repeat (2) @(negedge clk);
    logEn = 1'b0;
    expFrames = '{PENNY, NICKEL, DIME, QUARTER};
    checkLine("b2b");
    checkOutput("b2b_frames", frames_sent, 5);

    // Backpressure during an active frame
    base    = mAccepted;
    baseRx  = rxFrames;
    sawFull = 1'b0;
    applyStimulus(1'b1, 2'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 2'($urandom_range(0, 3)));
      if (req.coin_ready === 1'b0) sawFull = 1'b1;
    end
    applyStimulus(1'b0, 2'd0);
    waitIdle(150);
    checkOutput("bp_ready_fell", sawFull, 1);
    checkOutput("bp_tx_count", rxFrames - baseRx, 5);
    checkOutput("bp_tx_vs_accepted", rxFrames - baseRx, mAccepted - base);

    // Random traffic
    base   = mAccepted;
    baseRx = rxFrames;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)));
    end
    applyStimulus(1'b0, 2'd0);
    waitIdle(200);
    checkOutput("rand_tx_vs_accepted", rxFrames - baseRx, mAccepted - base);

    // Reset during bit 5 of a dime with two frames queued
    applyStimulus(1'b1, 2'd2);
    applyStimulus(1'b1, 2'd1);
    applyStimulus(1'b1, 2'd3);
    applyStimulus(1'b0, 2'd0);
    guard = 0;
    while (mPos != 5 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("midrst_busy_before", busy, 1);
    #1 reset = 1'b0;
    #1;
    checkOutput("midrst_serialOut", serialOut, 0);
    checkOutput("midrst_enable", enable, 1);
    checkOutput("midrst_frames", frames_sent, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_ready", req.coin_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    lineLog.delete();
    logEn = 1'b1;
    repeat (20) @(negedge clk);
    logEn = 1'b0;
    lowCount = 0;
    foreach (lineLog[i]) if (lineLog[i][1] == 1'b0) lowCount++;
    checkOutput("midrst_no_frame", lowCount, 0);
    checkOutput("midrst_busy_after", busy, 0);

    // Counter wrap with 257 quarters
    base   = mAccepted;
    baseRx = rxQuarters;
    fsLog.delete();
    fsLogEn = 1'b1;
    guard = 0;
    while (mAccepted - base < 257 && guard < 6000) begin
      applyStimulus(1'b1, 2'd3);
      guard++;
    end
    applyStimulus(1'b0, 2'd0);
    waitIdle(100);
    repeat (2) @(negedge clk);
    fsLogEn = 1'b0;
    checkOutput("wrap_frames", frames_sent, 1);
    checkOutput("wrap_quarters", rxQuarters - baseRx, 257);
    checkOutput("wrap_log_len", fsLog.size() >= 3, 1);
    if (fsLog.size() >= 3) begin
      checkOutput("wrap_seq_255", fsLog[fsLog.size() - 3], 255);
      checkOutput("wrap_seq_0", fsLog[fsLog.size() - 2], 0);
      checkOutput("wrap_seq_1", fsLog[fsLog.size() - 1], 1);
    end

    // Loopback credit: four quarters committed by the flush strobe, then a nickel
    baseCredit = rxCredit;
    repeat (4) applyStimulus(1'b1, 2'd3);
    applyStimulus(1'b0, 2'd0);
    waitIdle(100);
    checkOutput("loop_credit_100", rxCredit - baseCredit, 100);
    applyStimulus(1'b1, 2'd1);
    applyStimulus(1'b0, 2'd0);
    waitIdle(40);
    checkOutput("loop_credit_105", rxCredit - baseCredit, 105);

    chkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
